// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types, default sizes and the round-robin pointer
// helper for the shared-adder arbiter.
//   ADD_W / ADD_NREQ / ADD_IDW : default operand width, requester count, ID width
//   out_state_t                : response register state (EMPTY / FULL)
//   add_req_t / add_rsp_t      : one request / one response at default sizes
//   rr_next(ptr, n)            : (ptr + 1) mod n without a divider
package adder_arb_pkg;

    localparam int ADD_W    = 32;
    localparam int ADD_NREQ = 4;
    localparam int ADD_IDW  = $clog2(ADD_NREQ);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
        logic             sub;
    } add_req_t;

    typedef struct packed {
        logic [ADD_IDW-1:0] id;
        logic [ADD_W-1:0]   sum;
        logic               cout;
        logic               of;
    } add_rsp_t;

    // Wraps at n-1 -> 0 so a non power-of-two n never yields an index >= n.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rca_core.sv
// rca_core: purely combinational WIDTH-bit ripple-carry adder.
//   a_i, b_i  : operands
//   cin_i     : carry into bit 0
//   sum_o     : (a + b + cin) mod 2^WIDTH
//   cout_o    : carry out of the MSB
//   of_o      : signed overflow
module rca_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             of_o
);

    logic [WIDTH-1:0] sum;
    logic             carry;

    // Carry is a scalar walked bit by bit; this keeps the ripple chain
    // explicit without a self-referencing carry vector.
    always_comb begin
        sum   = '0;
        carry = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o  = sum;
    assign cout_o = carry;
    // Overflow: operands share a sign and the result sign differs from it.
    assign of_o   = (a_i[WIDTH-1] ~^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ sum[WIDTH-1]);

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one ripple-carry adder shared by NREQ requesters,
// round-robin arbitration, single registered response port with backpressure.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a requester holds valid and operands stable until accepted, and
// req_ready never depends on the response being consumed in the same cycle
// except through rsp_ready (drain and reload in one clock).
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid / req_ready : per-requester request handshake
//   req_a, req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin, req_sub      : carry-in, subtract select
//   rsp_valid / rsp_ready : response handshake
//   rsp_id, rsp_sum, rsp_cout, rsp_of : registered result and owner
// Optional macro ADDER_ARB_SUB_EN: builds the B inverter so req_sub=1
// computes a - b (carry-in forced to 1, req_cin ignored).
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = ADD_W,
    parameter int NREQ  = ADD_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_of
);

    out_state_t       state_q;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q, rsp_of_q;

    logic             can_load, found, accept;
    logic [IDW-1:0]   gnt_idx;
    int               scan_idx;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    assign can_load = (state_q == OUT_EMPTY) || rsp_ready;

    // Scan rr_ptr, rr_ptr+1, ... mod NREQ; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!found && req_valid[IDW'(scan_idx)]) begin
                found   = 1'b1;
                gnt_idx = IDW'(scan_idx);
            end
        end
    end

    // rst gates ready directly: the register is EMPTY during reset, so
    // can_load alone would otherwise grant.
    assign accept = found && can_load && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    assign rr_ptr_d = IDW'(rr_next(int'(gnt_idx), NREQ));

    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout, add_of;

`ifdef ADDER_ARB_SUB_EN
    assign eff_b   = req_sub[gnt_idx] ? ~b_arr[gnt_idx] : b_arr[gnt_idx];
    assign eff_cin = req_sub[gnt_idx] ? 1'b1 : req_cin[gnt_idx];
`else
    logic unused_sub;
    assign unused_sub = ^req_sub;
    assign eff_b      = b_arr[gnt_idx];
    assign eff_cin    = req_cin[gnt_idx];
`endif

    rca_core #(.WIDTH(WIDTH)) u_rca (
        .a_i    (a_arr[gnt_idx]),
        .b_i    (eff_b),
        .cin_i  (eff_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .of_o   (add_of)
    );

    // Accept wins over drain, so a simultaneous drain+accept reloads and
    // stays FULL (1 op/clk). Under backpressure nothing here changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OUT_EMPTY;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_of_q   <= 1'b0;
        end else if (accept) begin
            state_q    <= OUT_FULL;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= gnt_idx;
            rsp_sum_q  <= add_sum;
            rsp_cout_q <= add_cout;
            rsp_of_q   <= add_of;
        end else if (state_q == OUT_FULL && rsp_ready) begin
            state_q    <= OUT_EMPTY;
        end
    end

    assign rsp_valid = (state_q == OUT_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_of    = rsp_of_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  import adder_arb_pkg::*;

  localparam int W    = ADD_W;
  localparam int N    = ADD_NREQ;
  localparam int IDW  = ADD_IDW;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic [N-1:0]      req_cin;
  logic [N-1:0]      req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_of;

  int n_checks = 0;
  int n_errors = 0;
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] exp_id;
  logic [W-1:0]   exp_sub_sum;

  adder_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_of    (rsp_of)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic v, input add_req_t r);
    req_valid[i]       = v;
    req_a[i*W +: W]    = r.a;
    req_b[i*W +: W]    = r.b;
    req_cin[i]         = r.cin;
    req_sub[i]         = r.sub;
  endtask

  task automatic drop_all();
    req_valid = '0;
  endtask

  task automatic check_rsp(input string tag, input logic [IDW-1:0] id, input logic [W-1:0] sum,
                           input logic cout, input logic of);
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"},    64'(rsp_id),    64'(id));
    check({tag, "_sum"},   64'(rsp_sum),   64'(sum));
    check({tag, "_cout"},  64'(rsp_cout),  64'(cout));
    check({tag, "_of"},    64'(rsp_of),    64'(of));
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;

    // reset with every requester asking
    for (int i = 0; i < N; i++)
      drive_req(i, 1'b1, '{a: W'(i * 16), b: W'(1), cin: 1'b0, sub: 1'b0});
    step();
    step();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    check("rst_sum",   64'(rsp_sum),   64'd0);
    check("rst_cout",  64'(rsp_cout),  64'd0);
    check("rst_of",    64'(rsp_of),    64'd0);

    // release: first grant is requester 0, then round robin with no gaps
    rst = 1'b0;
    #1;
    check("first_grant", 64'(req_ready), 64'b0001);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    while (exp_q.size() > 0) begin
      step();
      exp_id = exp_q.pop_front();
      check_rsp("rr", exp_id, W'(int'(exp_id) * 16 + 1), 1'b0, 1'b0);
    end

    // reset mid-operation drops the pending response immediately
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    drop_all();
    #1;
    check("idle_ready", 64'(req_ready), 64'd0);

    // unsigned wrap
    drive_req(0, 1'b1, '{a: 32'hFFFF_FFFF, b: 32'd1, cin: 1'b0, sub: 1'b0});
    #1;
    check("wrap_ready", 64'(req_ready), 64'b0001);
    step();
    check_rsp("wrap", 2'd0, 32'h0000_0000, 1'b1, 1'b0);

    // signed overflow positive -> negative
    drop_all();
    drive_req(1, 1'b1, '{a: 32'h7FFF_FFFF, b: 32'd1, cin: 1'b0, sub: 1'b0});
    #1;
    check("ovf_ready", 64'(req_ready), 64'b0010);
    step();
    check_rsp("ovf", 2'd1, 32'h8000_0000, 1'b0, 1'b1);

    // backpressure for 3 clocks with req2 waiting
    drop_all();
    rsp_ready = 1'b0;
    drive_req(2, 1'b1, '{a: 32'd10, b: 32'd20, cin: 1'b0, sub: 1'b0});
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'd0);
      step();
      check_rsp("bp_hold", 2'd1, 32'h8000_0000, 1'b0, 1'b1);
    end
    // drain and reload in the same clock
    rsp_ready = 1'b1;
    #1;
    check("reload_ready", 64'(req_ready), 64'b0100);
    step();
    check_rsp("reload", 2'd2, 32'd30, 1'b0, 1'b0);

    // subtract select
    drop_all();
    drive_req(3, 1'b1, '{a: 32'd5, b: 32'd7, cin: 1'b0, sub: 1'b1});
`ifdef ADDER_ARB_SUB_EN
    exp_sub_sum = 32'hFFFF_FFFE;
`else
    exp_sub_sum = 32'd12;
`endif
    #1;
    check("sub_ready", 64'(req_ready), 64'b1000);
    step();
    check_rsp("sub", 2'd3, exp_sub_sum, 1'b0, 1'b0);

    // drain without accept: valid falls, data holds
    drop_all();
    req_sub = '0;
    step();
    check("drain_valid", 64'(rsp_valid), 64'd0);
    check("drain_id",    64'(rsp_id),    64'd3);
    check("drain_sum",   64'(rsp_sum),   64'(exp_sub_sum));

    // carry-in honoured
    drive_req(0, 1'b1, '{a: 32'd1, b: 32'd2, cin: 1'b1, sub: 1'b0});
    step();
    check_rsp("cin", 2'd0, 32'd4, 1'b0, 1'b0);

    // rr_ptr=1: req0 and req3 valid, scan 1,2,3 picks 3 first
    drive_req(0, 1'b1, '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, sub: 1'b0});
    drive_req(3, 1'b1, '{a: 32'd3, b: 32'd4, cin: 1'b0, sub: 1'b0});
    #1;
    check("skip_ready", 64'(req_ready), 64'b1000);
    step();
    check_rsp("skip", 2'd3, 32'd7, 1'b0, 1'b0);
    req_valid[3] = 1'b0;
    #1;
    check("wrap_ptr_ready", 64'(req_ready), 64'b0001);
    step();
    check_rsp("negovf", 2'd0, 32'd0, 1'b1, 1'b1);
    drop_all();
    step();
    check("end_valid", 64'(rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
